// File: rtl/soc_xbar_pkg.sv
// Configuration package for the SoC crossbar: slave address map,
// pending-request record and the address decoder shared by the top level.
package soc_xbar_pkg;

    localparam int NSLV_MAX = 8;
    localparam int SLV_W    = $clog2(NSLV_MAX);

    // Slave windows, index 0 in the rightmost slot: clint, print, bram.
    // Unused slots have base == top, so they never match.
    localparam logic [NSLV_MAX-1:0][31:0] SLV_BASE = {
        {5{32'h0000_0000}}, 32'h0000_0000, 32'h1000_0000, 32'h0200_0000
    };
    localparam logic [NSLV_MAX-1:0][31:0] SLV_TOP = {
        {5{32'h0000_0000}}, 32'h0010_0000, 32'h1000_1000, 32'h0200_C000
    };

    // Request held for a master that lost arbitration or found its slave busy.
    typedef struct packed {
        logic             valid;
        logic             instr;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [3:0]       wstrb;
        logic [SLV_W-1:0] slv;
    } pend_t;

    typedef struct packed {
        logic             hit;
        logic [SLV_W-1:0] slv;
    } dec_t;

    // Lowest matching slave index wins; the host alias is only consulted
    // when no window matches.
    function automatic dec_t slv_decode(input logic [31:0] addr,
                                        input logic [31:0] host_addr,
                                        input int          nslv,
                                        input logic        host_en,
                                        input int          host_slv);
        dec_t d;
        d.hit = 1'b0;
        d.slv = '0;
        for (int s = NSLV_MAX - 1; s >= 0; s--) begin
            if ((s < nslv) && (addr >= SLV_BASE[s]) && (addr < SLV_TOP[s])) begin
                d.hit = 1'b1;
                d.slv = SLV_W'(s);
            end
        end
        if (!d.hit && host_en && (addr == host_addr)) begin
            d.hit = 1'b1;
            d.slv = SLV_W'(host_slv);
        end
        return d;
    endfunction

endpackage

// File: rtl/soc_xbar_arb.sv
// Per-slave arbiter: tracks whether the slave has a request in flight,
// which master owns it, and who won the last grant for round-robin.
module xbar_arb #(
    parameter int ARB_MODE = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       rsp_i,
    output logic [1:0] grant_o,
    output logic       owner_o,
    output logic       rsp_o
);

    logic busy_q, busy_d;
    logic owner_q, owner_d;
    logic last_q, last_d;

    // Grant a free slave; on conflict data wins, or alternate in round-robin mode.
    always_comb begin
        grant_o = 2'b00;
        if (busy_q) begin
            grant_o = 2'b00;
        end else if (req_i == 2'b11) begin
            if (ARB_MODE == 0) begin
                grant_o = 2'b10;
            end else if (last_q) begin
                grant_o = 2'b01;
            end else begin
                grant_o = 2'b10;
            end
        end else begin
            grant_o = req_i;
        end
    end

    // Busy/owner/last-grant bookkeeping; a grant only happens on a free slave.
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (grant_o != 2'b00) begin
            busy_d  = 1'b1;
            owner_d = grant_o[1];
            last_d  = grant_o[1];
        end else if (rsp_i) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // State registers; last grant resets to the instruction master.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // A response counts only while a request is actually in flight.
    assign rsp_o   = rsp_i & busy_q;
    assign owner_o = owner_q;

endmodule

// File: rtl/soc_xbar.sv
// Two-master, N-slave crossbar: table-driven decode, per-master pending
// registers, per-slave arbitration and response routing.
module soc_xbar
    import soc_xbar_pkg::*;
#(
    parameter int NSLV     = 3,
    parameter int ARB_MODE = 0,
    parameter int HOST_EN  = 1,
    parameter int HOST_SLV = NSLV - 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                host_addr,
    input  logic [1:0]                 m_valid,
    input  logic [1:0]                 m_instr,
    input  logic [1:0][31:0]           m_addr,
    input  logic [1:0][31:0]           m_wdata,
    input  logic [1:0][3:0]            m_wstrb,
    output logic [1:0][31:0]           m_rdata,
    output logic [1:0]                 m_ready,
    output logic [1:0]                 m_err,
    output logic [NSLV-1:0]            s_valid,
    output logic [NSLV-1:0]            s_instr,
    output logic [NSLV-1:0][31:0]      s_addr,
    output logic [NSLV-1:0][31:0]      s_wdata,
    output logic [NSLV-1:0][3:0]       s_wstrb,
    input  logic [NSLV-1:0][31:0]      s_rdata,
    input  logic [NSLV-1:0]            s_ready
);

    pend_t [1:0]           pend_q, pend_d;
    pend_t [1:0]           cur_s;
    dec_t  [1:0]           dec_s;
    logic  [1:0]           err_q, err_d;
    logic  [1:0]           granted_s;
    logic  [NSLV-1:0][1:0] req_s;
    logic  [NSLV-1:0][1:0] grant_s;
    logic  [NSLV-1:0]      owner_s;
    logic  [NSLV-1:0]      rsp_s;

    // Decode the incoming address of each master.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            dec_s[m] = slv_decode(m_addr[m], host_addr, NSLV, HOST_EN != 0, HOST_SLV);
        end
    end

    // Present the pending request if any, else the new one; flag unmapped accesses.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            if (pend_q[m].valid) begin
                cur_s[m] = pend_q[m];
            end else begin
                cur_s[m].valid = m_valid[m] & dec_s[m].hit;
                cur_s[m].instr = m_instr[m];
                cur_s[m].addr  = m_addr[m];
                cur_s[m].wdata = m_wdata[m];
                cur_s[m].wstrb = m_wstrb[m];
                cur_s[m].slv   = dec_s[m].slv;
            end
            cur_s[m].valid = cur_s[m].valid & reset;
            err_d[m] = reset & m_valid[m] & ~pend_q[m].valid & ~dec_s[m].hit;
        end
    end

    // Build per-slave request vectors from the presented requests.
    always_comb begin
        for (int s = 0; s < NSLV; s++) begin
            for (int m = 0; m < 2; m++) begin
                req_s[s][m] = cur_s[m].valid && (cur_s[m].slv == SLV_W'(s));
            end
        end
    end

    // One arbiter per slave.
    for (genvar s = 0; s < NSLV; s++) begin : g_arb
        xbar_arb #(.ARB_MODE(ARB_MODE)) u_arb (
            .clock   (clock),
            .reset   (reset),
            .req_i   (req_s[s]),
            .rsp_i   (s_ready[s]),
            .grant_o (grant_s[s]),
            .owner_o (owner_s[s]),
            .rsp_o   (rsp_s[s])
        );
    end

    // Collapse the per-slave grants into one issued flag per master.
    always_comb begin
        granted_s = 2'b00;
        for (int s = 0; s < NSLV; s++) begin
            granted_s = granted_s | grant_s[s];
        end
    end

    // A presented request that was not granted stays pending.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            pend_d[m]       = cur_s[m];
            pend_d[m].valid = cur_s[m].valid & ~granted_s[m];
        end
    end

    // Pending and unmapped-error registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            err_q  <= 2'b00;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // Drive the granted request onto each slave; idle slaves see zeros.
    always_comb begin
        s_valid = '0;
        s_instr = '0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        for (int s = 0; s < NSLV; s++) begin
            if (grant_s[s] != 2'b00) begin
                s_valid[s] = 1'b1;
                s_instr[s] = cur_s[grant_s[s][1]].instr;
                s_addr[s]  = cur_s[grant_s[s][1]].addr - SLV_BASE[cur_s[grant_s[s][1]].slv];
                s_wdata[s] = cur_s[grant_s[s][1]].wdata;
                s_wstrb[s] = cur_s[grant_s[s][1]].wstrb;
            end else begin
                s_valid[s] = 1'b0;
            end
        end
    end

    // Route slave responses to their owners and report unmapped errors.
    always_comb begin
        m_ready = err_q;
        m_err   = err_q;
        m_rdata = '0;
        for (int s = 0; s < NSLV; s++) begin
            m_ready[owner_s[s]] = m_ready[owner_s[s]] | rsp_s[s];
            m_rdata[owner_s[s]] = m_rdata[owner_s[s]] | (s_rdata[s] & {32{rsp_s[s]}});
        end
    end

endmodule

// File: tb/tb_soc_xbar.sv
// Randomised bench for soc_xbar: one instance per arbitration mode, each
// checked every cycle against a transaction-level model of the crossbar.
module tb_soc_xbar;

    localparam int          NS   = 3;
    localparam logic [31:0] HOST = 32'h8000_1000;
    localparam logic [31:0] BASE [NS] = '{32'h0200_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [31:0] TOP  [NS] = '{32'h0200_C000, 32'h1000_1000, 32'h0010_0000};
    localparam logic [31:0] EDGE [9]  = '{32'h0200_BFFF, 32'h0200_C000, 32'h01FF_FFFF,
                                          32'h1000_0FFF, 32'h1000_1000, 32'h000F_FFFF,
                                          32'h0010_0000, 32'h8000_0FFF, 32'h8000_1001};

    typedef struct packed {
        logic        v;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  tgt;
    } req_t;

    logic                  clock;
    logic                  reset;
    logic [31:0]           host_addr;
    logic [1:0]            m_valid [2];
    logic [1:0]            m_instr [2];
    logic [1:0][31:0]      m_addr  [2];
    logic [1:0][31:0]      m_wdata [2];
    logic [1:0][3:0]       m_wstrb [2];
    logic [1:0][31:0]      m_rdata [2];
    logic [1:0]            m_ready [2];
    logic [1:0]            m_err   [2];
    logic [NS-1:0]         s_valid [2];
    logic [NS-1:0]         s_instr [2];
    logic [NS-1:0][31:0]   s_addr  [2];
    logic [NS-1:0][31:0]   s_wdata [2];
    logic [NS-1:0][3:0]    s_wstrb [2];
    logic [NS-1:0][31:0]   s_rdata [2];
    logic [NS-1:0]         s_ready [2];

    int n_checks;
    int n_errors;

    // Reference model state, per instance k.
    req_t        wait_r   [2][2];
    int          holder   [2][NS];
    int          last_g   [2][NS];
    bit          err_due  [2][2];
    int          job_cnt  [2][NS];
    logic [31:0] job_data [2][NS];
    int          quiet;

    soc_xbar #(.NSLV(NS), .ARB_MODE(0), .HOST_EN(1), .HOST_SLV(2)) dut0 (
        .clock(clock), .reset(reset), .host_addr(host_addr),
        .m_valid(m_valid[0]), .m_instr(m_instr[0]), .m_addr(m_addr[0]),
        .m_wdata(m_wdata[0]), .m_wstrb(m_wstrb[0]), .m_rdata(m_rdata[0]),
        .m_ready(m_ready[0]), .m_err(m_err[0]), .s_valid(s_valid[0]),
        .s_instr(s_instr[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
        .s_wstrb(s_wstrb[0]), .s_rdata(s_rdata[0]), .s_ready(s_ready[0])
    );

    soc_xbar #(.NSLV(NS), .ARB_MODE(1), .HOST_EN(1), .HOST_SLV(2)) dut1 (
        .clock(clock), .reset(reset), .host_addr(host_addr),
        .m_valid(m_valid[1]), .m_instr(m_instr[1]), .m_addr(m_addr[1]),
        .m_wdata(m_wdata[1]), .m_wstrb(m_wstrb[1]), .m_rdata(m_rdata[1]),
        .m_ready(m_ready[1]), .m_err(m_err[1]), .s_valid(s_valid[1]),
        .s_instr(s_instr[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
        .s_wstrb(s_wstrb[1]), .s_rdata(s_rdata[1]), .s_ready(s_ready[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int s = 0; s < NS; s++) begin
            if (a >= BASE[s] && a < TOP[s]) return s;
        end
        if (a == HOST) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       return 32'h0200_0000 + (r % 32'h0000_C000);
            1:       return 32'h1000_0000 + (r % 32'h0000_1000);
            2, 3:    return r % 32'h0010_0000;
            4:       return HOST;
            5:       return 32'h4000_0000 + (r % 32'h1000_0000);
            6:       return EDGE[int'(r % 32'd9)];
            default: return 32'h0000_0100;
        endcase
    endfunction

    function automatic bit is_idle(input int k, input int m);
        bit idle;
        idle = !wait_r[k][m].v && !err_due[k][m];
        for (int s = 0; s < NS; s++) begin
            if (holder[k][s] == m) idle = 1'b0;
        end
        return idle;
    endfunction

    // One clock cycle: drive at negedge, check before posedge, advance model.
    task automatic do_cycle(input bit rst_low);
        req_t                nreq [2];
        req_t                cand [2];
        bit                  nerr [2];
        int                  grant [NS];
        int                  win, d;
        bit                  w0, w1;
        logic [1:0]          e_rdy, e_err;
        logic [1:0][31:0]    e_rd;
        logic [NS-1:0]       e_sv, e_si;
        logic [NS-1:0][31:0] e_sa, e_sw;
        logic [NS-1:0][3:0]  e_ss;

        @(negedge clock);
        reset = ~rst_low;
        for (int k = 0; k < 2; k++) begin
            // Master stimulus: only idle masters issue; during reset drive noise.
            for (int m = 0; m < 2; m++) begin
                m_addr[k][m]  = pick_addr();
                m_wdata[k][m] = $urandom;
                m_wstrb[k][m] = 4'($urandom_range(0, 15));
                m_instr[k][m] = 1'($urandom_range(0, 1));
                if (rst_low) begin
                    m_valid[k][m] = 1'($urandom_range(0, 1));
                end else if (quiet == 0 && is_idle(k, m) && $urandom_range(0, 99) < 55) begin
                    m_valid[k][m] = 1'b1;
                end else begin
                    m_valid[k][m] = 1'b0;
                end
                assert (rst_low || !m_valid[k][m] || is_idle(k, m))
                    else $error("protocol violation on master %0d", m);
            end
            // Slave models: answer scheduled jobs, occasionally send a stray response.
            for (int s = 0; s < NS; s++) begin
                s_rdata[k][s] = $urandom;
                if (job_cnt[k][s] == 1) begin
                    s_ready[k][s] = 1'b1;
                    s_rdata[k][s] = job_data[k][s];
                end else if (job_cnt[k][s] == 0 && $urandom_range(0, 9) == 0) begin
                    s_ready[k][s] = 1'b1;
                end else begin
                    s_ready[k][s] = 1'b0;
                end
            end
        end
        #3;
        for (int k = 0; k < 2; k++) begin
            e_rdy = '0; e_err = '0; e_rd = '0;
            e_sv = '0; e_si = '0; e_sa = '0; e_sw = '0; e_ss = '0;
            for (int s = 0; s < NS; s++) grant[s] = -1;
            for (int m = 0; m < 2; m++) begin
                d = decode(m_addr[k][m]);
                nreq[m] = '{v: m_valid[k][m] && d >= 0, instr: m_instr[k][m],
                            addr: m_addr[k][m], wdata: m_wdata[k][m],
                            wstrb: m_wstrb[k][m], tgt: (d >= 0) ? 2'(d) : 2'd0};
                nerr[m] = m_valid[k][m] && d < 0;
                cand[m] = wait_r[k][m].v ? wait_r[k][m] : nreq[m];
            end
            if (!rst_low) begin
                for (int m = 0; m < 2; m++) begin
                    e_rdy[m] = err_due[k][m];
                    e_err[m] = err_due[k][m];
                end
                for (int s = 0; s < NS; s++) begin
                    if (holder[k][s] >= 0 && s_ready[k][s]) begin
                        e_rdy[holder[k][s]] = 1'b1;
                        e_rd[holder[k][s]]  = s_rdata[k][s];
                    end
                end
                for (int s = 0; s < NS; s++) begin
                    if (holder[k][s] < 0) begin
                        w0 = cand[0].v && int'(cand[0].tgt) == s;
                        w1 = cand[1].v && int'(cand[1].tgt) == s;
                        win = -1;
                        if (w0 && w1) win = (k == 0) ? 1 : 1 - last_g[k][s];
                        else if (w1) win = 1;
                        else if (w0) win = 0;
                        if (win >= 0) begin
                            grant[s] = win;
                            e_sv[s] = 1'b1;
                            e_si[s] = cand[win].instr;
                            e_sa[s] = cand[win].addr - BASE[s];
                            e_sw[s] = cand[win].wdata;
                            e_ss[s] = cand[win].wstrb;
                        end
                    end
                end
            end
            // Compare.
            check_eq($sformatf("dut%0d s_valid", k), 32'(s_valid[k]), 32'(e_sv));
            check_eq($sformatf("dut%0d s_instr", k), 32'(s_instr[k]), 32'(e_si));
            for (int s = 0; s < NS; s++) begin
                check_eq($sformatf("dut%0d s_addr[%0d]", k, s), s_addr[k][s], e_sa[s]);
                check_eq($sformatf("dut%0d s_wdata[%0d]", k, s), s_wdata[k][s], e_sw[s]);
                check_eq($sformatf("dut%0d s_wstrb[%0d]", k, s), 32'(s_wstrb[k][s]), 32'(e_ss[s]));
            end
            check_eq($sformatf("dut%0d m_ready", k), 32'(m_ready[k]), 32'(e_rdy));
            check_eq($sformatf("dut%0d m_err", k), 32'(m_err[k]), 32'(e_err));
            for (int m = 0; m < 2; m++) begin
                if (e_rdy[m] || rst_low) begin
                    check_eq($sformatf("dut%0d m_rdata[%0d]", k, m), m_rdata[k][m], e_rd[m]);
                end
            end
            // Advance model.
            for (int s = 0; s < NS; s++) begin
                if (job_cnt[k][s] > 0) job_cnt[k][s]--;
            end
            if (rst_low) begin
                for (int m = 0; m < 2; m++) begin
                    wait_r[k][m] = '0;
                    err_due[k][m] = 1'b0;
                end
                for (int s = 0; s < NS; s++) begin
                    holder[k][s] = -1;
                    last_g[k][s] = 0;
                end
            end else begin
                for (int s = 0; s < NS; s++) begin
                    if (holder[k][s] >= 0 && s_ready[k][s]) holder[k][s] = -1;
                end
                for (int m = 0; m < 2; m++) begin
                    err_due[k][m] = nerr[m];
                    wait_r[k][m]  = cand[m];
                end
                for (int s = 0; s < NS; s++) begin
                    if (grant[s] >= 0) begin
                        wait_r[k][grant[s]].v = 1'b0;
                        holder[k][s]   = grant[s];
                        last_g[k][s]   = grant[s];
                        job_cnt[k][s]  = int'($urandom_range(1, 3));
                        job_data[k][s] = $urandom;
                    end
                end
            end
        end
        if (rst_low) quiet = 5;
        else if (quiet > 0) quiet--;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        quiet     = 0;
        reset     = 1'b0;
        host_addr = HOST;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = '0; m_instr[k] = '0; m_addr[k] = '0;
            m_wdata[k] = '0; m_wstrb[k] = '0;
            s_rdata[k] = '0; s_ready[k] = '0;
            for (int m = 0; m < 2; m++) begin
                wait_r[k][m]  = '0;
                err_due[k][m] = 1'b0;
            end
            for (int s = 0; s < NS; s++) begin
                holder[k][s]   = -1;
                last_g[k][s]   = 0;
                job_cnt[k][s]  = 0;
                job_data[k][s] = '0;
            end
        end
        do_cycle(1'b1);
        do_cycle(1'b1);
        for (int c = 0; c < 3000; c++) begin
            do_cycle(c == 1000 || c == 2000 || c == 2500);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
